dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data_memory between two requesters: port 0 (CPU load/store unit)
//   and port 1 (DMA/debug). Uses round-robin arbitration and a valid/ready request handshake.
//   A registered response returns read data or a write acknowledge.
//   Sub-word stores (byte enables != 4'hF) become a read-modify-write on the word-wide memory.
// PARAMETERS
//   FIXED_PRIO  0   0 = round-robin; 1 = port 0 always wins when both ports request
//   ADDR_W      32  request/memory address width; addr[1:0] is ignored (word access)
// PORTS
//   clk             in   1       single clock, rising edge
//   rst             in   1       synchronous, active-high reset
//   pN_req_valid    in   1       request valid, N = 0, 1
//   pN_req_ready    out  1       request accepted this cycle when valid && ready
//   pN_req_we       in   1       1 = write, 0 = read
//   pN_req_addr     in   ADDR_W  byte address
//   pN_req_wdata    in   32      write data, lane-aligned (byte k on bits 8k+7:8k)
//   pN_req_be       in   4       byte enables, writes only
//   pN_rsp_valid    out  1       one-cycle pulse: read data valid / write done
//   pN_rsp_rdata    out  32      read word; 0 for writes
//   mem_we          out  1       data_memory write enable, sampled at posedge clk
//   mem_addr        out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//   mem_wdata       out  32      data_memory write data
//   mem_rdata       in   32      data_memory read data, combinational from mem_addr
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//     - Registered state: state=IDLE, all rsp_valid=0, rsp_rdata=0, last_grant=1.
//     - Outputs during reset: mem_we=0 and req_ready=0 combinationally; memory is never
//       written in a reset cycle.
//     - Reset mid-operation drops the in-flight request with no response. A requester still
//       holding valid is re-accepted after reset.
//   FSM states: IDLE -> ACCESS -> (MERGE) -> IDLE.
//     - IDLE: grant = sole valid port. If both are valid: the port != last_grant
//       (round-robin), or port 0 if FIXED_PRIO=1. req_ready=1 for the granted port only.
//       On handshake, latch we/addr/wdata/be/port and set last_grant.
//     - ACCESS, read: mem_addr=latched addr; capture mem_rdata into rsp_rdata; -> IDLE.
//     - ACCESS, write with be=4'hF: mem_we=1, mem_wdata=wdata; -> IDLE.
//     - ACCESS, write with be=4'h0: no mem_we; acknowledge only; -> IDLE.
//     - ACCESS, write with partial be: capture mem_rdata into the merge register, no write;
//       -> MERGE.
//     - MERGE: mem_we=1; mem_wdata per byte k = be[k] ? wdata byte k : old byte k; -> IDLE.
//   Response: rsp_valid rises for exactly one cycle on the granted port, in the cycle the
//     FSM re-enters IDLE. The other port's rsp_valid stays 0.
//   Latency, handshake at cycle T:
//     - read / full or empty write: rsp at T+2.
//     - partial write: rsp at T+3.
//   A new handshake may occur in the same cycle a response is presented. Maximum throughput
//     is 1 access per 2 cycles (3 for partial writes).
//   Outside ACCESS/MERGE: mem_we=0 and mem_addr/mem_wdata hold their last values. Never
//     drive X.
//   Requester rule: request fields must stay stable while valid && !ready. The arbiter does
//     not check this.
//   Addresses wrap modulo memory size in data_memory. No range checking here.
// TESTING
//   1 Reset, p0 read addr 0x4 (mem word=0x0) -> p0_rsp_valid at T+2, rdata 0x00000000,
//     p1_rsp_valid stays 0.
//   2 p1 write addr 0x8 data 0xDEADBEEF be=F -> mem_we=1 for exactly one cycle (T+1);
//     p1 read 0x8 returns 0xDEADBEEF.
//   3 Word 0x8=0xDEADBEEF; p0 write data 0x00AA0000 be=4'b0100 -> no mem_we at T+1,
//     mem_we at T+2, rsp at T+3; read back 0xDEAABEEF.
//   4 Both valid every cycle for 6 grants after reset -> grants alternate p0,p1,p0,...
//     With FIXED_PRIO=1, p1 never granted while p0 valid.
//   5 rst asserted in MERGE cycle of a partial write -> no mem_we, no rsp_valid, word
//     unchanged; held request re-accepted after reset.
//   6 Write be=0 to addr 0xC -> rsp_valid at T+2, mem_we never 1, word 0xC unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port word memory. Round-robin or fixed
// priority grant, registered responses, byte-masked stores done as read-modify-write.
module dmem_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [31:0]       p0_req_wdata,
    input  logic [3:0]        p0_req_be,
    output logic              p0_rsp_valid,
    output logic [31:0]       p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [31:0]       p1_req_wdata,
    input  logic [3:0]        p1_req_be,
    output logic              p1_rsp_valid,
    output logic [31:0]       p1_rsp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;

    state_t            state, state_next;
    logic              last_grant;
    logic              grant_any, grant_port, take;
    logic              we_q, port_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, merge_q, wdata_hold;
    logic [3:0]        be_q;
    logic              partial_wr, full_wr, done;
    logic [31:0]       rsp_word;
    logic              unused_addr_lsb;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) result[8*k +: 8] = new_word[8*k +: 8];
        end
        return result;
    endfunction

    // Both valid: alternate away from the previous winner unless port 0 is pinned.
    always_comb begin
        grant_any  = 1'b0;
        grant_port = 1'b0;
        if (p0_req_valid && p1_req_valid) begin
            grant_any  = 1'b1;
            grant_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else if (p0_req_valid) begin
            grant_any  = 1'b1;
            grant_port = 1'b0;
        end else if (p1_req_valid) begin
            grant_any  = 1'b1;
            grant_port = 1'b1;
        end
    end

    assign take         = (state == IDLE) && grant_any && !rst;
    assign p0_req_ready = take && !grant_port;
    assign p1_req_ready = take && grant_port;

    assign full_wr    = we_q && (be_q == 4'hF);
    assign partial_wr = we_q && (be_q != 4'hF) && (be_q != 4'h0);
    assign done       = ((state == ACCESS) && !partial_wr) || (state == MERGE);
    assign rsp_word   = we_q ? 32'h0 : mem_rdata;

    assign mem_addr        = {addr_q[ADDR_W-1:2], 2'b00};
    assign unused_addr_lsb = ^addr_q[1:0];

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_wdata  = wdata_hold;
        case (state)
            IDLE: begin
                if (take) state_next = ACCESS;
            end
            ACCESS: begin
                mem_wdata  = wdata_q;
                mem_we     = full_wr;
                state_next = partial_wr ? MERGE : IDLE;
            end
            MERGE: begin
                mem_wdata  = merge_bytes(merge_q, wdata_q, be_q);
                mem_we     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // addr_q and wdata_hold are reset so the memory bus never shows X.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p0_rsp_rdata <= 32'h0;
            p1_rsp_rdata <= 32'h0;
            addr_q       <= '0;
            wdata_hold   <= 32'h0;
        end else begin
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            if (take) begin
                last_grant <= grant_port;
                addr_q     <= grant_port ? p1_req_addr : p0_req_addr;
            end
            if (state == ACCESS || state == MERGE) wdata_hold <= mem_wdata;
            if (done) begin
                if (port_q) begin
                    p1_rsp_valid <= 1'b1;
                    p1_rsp_rdata <= rsp_word;
                end else begin
                    p0_rsp_valid <= 1'b1;
                    p0_rsp_rdata <= rsp_word;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            port_q  <= grant_port;
            we_q    <= grant_port ? p1_req_we    : p0_req_we;
            wdata_q <= grant_port ? p1_req_wdata : p0_req_wdata;
            be_q    <= grant_port ? p1_req_be    : p0_req_be;
        end
        if (state == ACCESS) merge_q <= mem_rdata;
    end

endmodule
